ex_stage_seq: RTL

Registered, parametrised execute stage for the MUSA core: selects ALU operands, executes single-cycle ALU ops and iterative unsigned multiply/divide, resolves branches, and computes the next PC. It sits between the ID/EX and EX/MEM boundaries. A valid/ready handshake on both sides lets a multi-cycle operation stall the pipeline upstream while downstream back-pressure is honoured.

---
 rtl/ex_pkg.sv | 61 ++++++
 rtl/ex_muldiv_iter.sv | 117 +++++++++++
 rtl/ex_stage_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// ============================================================================
// Module      : ex_pkg
// Description : Shared encodings for the MUSA execute stage: ALU control,
//               R-type function codes, operand selects, next-PC selects,
//               flag bit positions and the execute FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_pkg;

  // alu_control encodings
  localparam logic [2:0] c_ALU_ADD   = 3'b000;
  localparam logic [2:0] c_ALU_SUB   = 3'b001;
  localparam logic [2:0] c_ALU_AND   = 3'b010;
  localparam logic [2:0] c_ALU_OR    = 3'b011;
  localparam logic [2:0] c_ALU_XOR   = 3'b100;
  localparam logic [2:0] c_ALU_SLT   = 3'b101;
  localparam logic [2:0] c_ALU_RTYPE = 3'b110;
  localparam logic [2:0] c_ALU_PASSB = 3'b111;

  // R-type function codes
  localparam logic [5:0] c_FN_SLL   = 6'h00;
  localparam logic [5:0] c_FN_MFHI  = 6'h10;
  localparam logic [5:0] c_FN_MULTU = 6'h18;
  localparam logic [5:0] c_FN_DIVU  = 6'h1A;
  localparam logic [5:0] c_FN_ADD   = 6'h20;
  localparam logic [5:0] c_FN_SUB   = 6'h22;
  localparam logic [5:0] c_FN_AND   = 6'h24;
  localparam logic [5:0] c_FN_OR    = 6'h25;
  localparam logic [5:0] c_FN_SLT   = 6'h2A;

  // Operand selects
  localparam logic [1:0] c_ASEL_PC    = 2'd0;
  localparam logic [1:0] c_ASEL_PC1   = 2'd1;
  localparam logic [1:0] c_ASEL_DATA  = 2'd2;
  localparam logic [1:0] c_BSEL_IMM   = 2'd0;
  localparam logic [1:0] c_BSEL_DATA  = 2'd1;
  localparam logic [1:0] c_BSEL_IMMS2 = 2'd2;

  // pc_select encodings (5..7 fall back to pc_1)
  localparam logic [2:0] c_PC_SEL_SEQ    = 3'd0;
  localparam logic [2:0] c_PC_SEL_JUMP   = 3'd1;
  localparam logic [2:0] c_PC_SEL_BRANCH = 3'd2;
  localparam logic [2:0] c_PC_SEL_STACK  = 3'd3;
  localparam logic [2:0] c_PC_SEL_JR     = 3'd4;

  // flag bit indices
  localparam int c_FLAG_ZERO = 0;
  localparam int c_FLAG_NEG  = 1;
  localparam int c_FLAG_ERR  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MULDIV = 2'd1,
    ST_HOLD   = 2'd2
  } ex_state_t;

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_iter.sv
// ============================================================================
// Module      : ex_muldiv_iter
// Description : Iterative unsigned multiply (shift-add) / divide (restoring)
//               unit with the hi register. One step per cycle, DATA_W steps.
//               A zero divisor finishes on the first busy cycle with
//               lo = all-ones, hi = dividend and err set.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_flush       - abort an in-flight operation (hi kept)
//               i_start       - latch operands and begin (i_div selects divu)
//               i_a, i_b      - multiplicand/dividend, multiplier/divisor
//               o_busy        - operation in progress
//               o_done        - final step this cycle (o_lo/o_err valid)
//               o_lo, o_err   - low product / quotient and error flag
//               o_hi          - hi register (high product / remainder)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_muldiv_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_start,
  input  logic              i_div,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_lo,
  output logic              o_err,
  output logic [DATA_W-1:0] o_hi
);

  localparam int c_CNT_W = $clog2(DATA_W + 1);

  logic               r_busy, r_div, r_div0, r_err;
  logic [c_CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0]  r_acc, r_q, r_d, r_lo, r_hi;

  logic [DATA_W:0]    w_sum, w_shift, w_diff;
  logic [DATA_W-1:0]  w_acc_nx, w_q_nx, w_lo_fin, w_hi_fin;

  // {r_acc, r_q} is the double-width working register for both operations:
  // product accumulates from the top, quotient bits shift in at the bottom.
  always_comb begin
    w_sum    = {1'b0, r_acc} + {1'b0, r_d};
    w_shift  = {r_acc, r_q[DATA_W-1]};
    w_diff   = w_shift - {1'b0, r_d};
    w_acc_nx = r_acc;
    w_q_nx   = r_q;
    if (r_div) begin
      // Borrow out of the top bit means the trial subtract went negative.
      if (!w_diff[DATA_W]) begin
        w_acc_nx = w_diff[DATA_W-1:0];
        w_q_nx   = {r_q[DATA_W-2:0], 1'b1};
      end else begin
        w_acc_nx = w_shift[DATA_W-1:0];
        w_q_nx   = {r_q[DATA_W-2:0], 1'b0};
      end
    end else if (r_q[0]) begin
      w_acc_nx = w_sum[DATA_W:1];
      w_q_nx   = {w_sum[0], r_q[DATA_W-1:1]};
    end else begin
      w_acc_nx = {1'b0, r_acc[DATA_W-1:1]};
      w_q_nx   = {r_acc[0], r_q[DATA_W-1:1]};
    end
  end

  assign w_lo_fin = r_div0 ? {DATA_W{1'b1}} : w_q_nx;
  assign w_hi_fin = r_div0 ? r_q : w_acc_nx;

  assign o_done = r_busy && (r_div0 || (r_cnt == c_CNT_W'(1)));
  assign o_busy = r_busy;
  assign o_lo   = r_busy ? w_lo_fin : r_lo;
  assign o_err  = r_busy ? r_div0 : r_err;
  assign o_hi   = r_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_div  <= 1'b0;
      r_div0 <= 1'b0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_lo   <= '0;
      r_hi   <= '0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_div  <= i_div;
      r_div0 <= i_div && (i_b == '0);
      r_cnt  <= c_CNT_W'(DATA_W);
      r_acc  <= '0;
      r_q    <= i_a;
      r_d    <= i_b;
    end else if (r_busy) begin
      r_acc <= w_acc_nx;
      r_q   <= w_q_nx;
      r_cnt <= r_cnt - c_CNT_W'(1);
      if (o_done) begin
        r_busy <= 1'b0;
        r_lo   <= w_lo_fin;
        r_hi   <= w_hi_fin;
        r_err  <= r_div0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_stage_seq.sv
// ============================================================================
// Module      : ex_stage_seq
// Description : Registered execute stage: operand select, single-cycle ALU,
//               iterative multu/divu, branch resolution and next-PC, with
//               valid/ready handshakes on input and output.
// Config      : EX_MULDIV_EN - when defined, multu/divu/mfhi use the
//               iterative unit and hi register; otherwise they complete in
//               one cycle with result 0 and flag[2] set, busy tied low.
// Ports       : clock, reset, flush       - clock, sync reset, sync kill
//               in_valid/in_ready         - input handshake
//               data_a, data_b, immediate - operands
//               pc, pc_1, jump_address, stack - PC sources
//               data_a_select, data_b_select, alu_control, func, pc_select
//               out_valid/out_ready       - output handshake
//               result, flag, next_pc     - registered result bundle
//               busy                      - multiply/divide in progress
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage_seq
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic [DATA_W-1:0] immediate,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pc_1,
  input  logic [ADDR_W-1:0] jump_address,
  input  logic [ADDR_W-1:0] stack,
  input  logic [1:0]        data_a_select,
  input  logic [1:0]        data_b_select,
  input  logic [2:0]        alu_control,
  input  logic [5:0]        func,
  input  logic [2:0]        pc_select,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        flag,
  output logic [ADDR_W-1:0] next_pc,
  output logic              busy
);

  ex_state_t         r_state, w_state_nx;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_result;
  logic [2:0]        r_flag;
  logic [ADDR_W-1:0] r_next_pc;

  logic [DATA_W-1:0] w_a, w_b, w_alu;
  logic              w_err;
  logic [2:0]        w_flag;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_accept, w_fire, w_single;

  always_comb begin
    case (data_a_select)
      c_ASEL_PC:   w_a = DATA_W'(pc);
      c_ASEL_PC1:  w_a = DATA_W'(pc_1);
      c_ASEL_DATA: w_a = data_a;
      default:     w_a = '0;
    endcase
    case (data_b_select)
      c_BSEL_IMM:   w_b = immediate;
      c_BSEL_DATA:  w_b = data_b;
      c_BSEL_IMMS2: w_b = immediate >> 2;
      default:      w_b = '0;
    endcase
  end

`ifdef EX_MULDIV_EN
  logic              w_md_op, w_md_busy, w_md_done, w_md_err, w_md_commit;
  logic [DATA_W-1:0] w_md_lo, w_hi;
  logic [2:0]        w_md_flag;
  logic [ADDR_W-1:0] r_pend_pc;

  assign w_md_op = (alu_control == c_ALU_RTYPE) &&
                   ((func == c_FN_MULTU) || (func == c_FN_DIVU));

  ex_muldiv_iter #(.DATA_W(DATA_W)) u_muldiv (
    .clk     (clock),
    .rst     (reset),
    .i_flush (flush),
    .i_start (w_accept && w_md_op),
    .i_div   (func == c_FN_DIVU),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_busy  (w_md_busy),
    .o_done  (w_md_done),
    .o_lo    (w_md_lo),
    .o_err   (w_md_err),
    .o_hi    (w_hi)
  );

  assign busy     = w_md_busy;
  assign w_single = w_accept && !w_md_op;
  // Result enters the output register either straight off the last step or,
  // if the register was still occupied, once downstream drains it.
  assign w_md_commit = ((r_state == ST_MULDIV) && w_md_done && (!r_out_valid || out_ready)) ||
                       ((r_state == ST_HOLD) && out_ready);

  always_comb begin
    w_md_flag              = '0;
    w_md_flag[c_FLAG_ZERO] = (w_md_lo == '0);
    w_md_flag[c_FLAG_NEG]  = w_md_lo[DATA_W-1];
    w_md_flag[c_FLAG_ERR]  = w_md_err;
  end
`else
  assign busy     = 1'b0;
  assign w_single = w_accept;
`endif

  always_comb begin
    w_alu = '0;
    w_err = 1'b0;
    case (alu_control)
      c_ALU_ADD:   w_alu = w_a + w_b;
      c_ALU_SUB:   w_alu = w_a - w_b;
      c_ALU_AND:   w_alu = w_a & w_b;
      c_ALU_OR:    w_alu = w_a | w_b;
      c_ALU_XOR:   w_alu = w_a ^ w_b;
      c_ALU_SLT:   w_alu[0] = ($signed(w_a) < $signed(w_b));
      c_ALU_RTYPE: begin
        case (func)
          c_FN_ADD: w_alu = w_a + w_b;
          c_FN_SUB: w_alu = w_a - w_b;
          c_FN_AND: w_alu = w_a & w_b;
          c_FN_OR:  w_alu = w_a | w_b;
          c_FN_SLT: w_alu[0] = ($signed(w_a) < $signed(w_b));
          c_FN_SLL: w_alu = w_a << w_b[4:0];
`ifdef EX_MULDIV_EN
          c_FN_MFHI: w_alu = w_hi;
`else
          c_FN_MFHI, c_FN_MULTU, c_FN_DIVU: w_err = 1'b1;
`endif
          default: w_alu = '0;
        endcase
      end
      default:     w_alu = w_b;
    endcase
  end

  always_comb begin
    w_flag              = '0;
    w_flag[c_FLAG_ZERO] = (w_alu == '0);
    w_flag[c_FLAG_NEG]  = w_alu[DATA_W-1];
    w_flag[c_FLAG_ERR]  = w_err;
  end

  // Branch compares the selected operands; target is relative to pc_1.
  always_comb begin
    case (pc_select)
      c_PC_SEL_JUMP:   w_next_pc = jump_address;
      c_PC_SEL_BRANCH: w_next_pc = (w_a == w_b) ? (pc_1 + ADDR_W'(immediate)) : pc_1;
      c_PC_SEL_STACK:  w_next_pc = stack;
      c_PC_SEL_JR:     w_next_pc = ADDR_W'(data_a);
      default:         w_next_pc = pc_1;
    endcase
  end

  // Reset gates in_ready so it rises only once reset is released.
  assign in_ready = !reset && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready && !flush;
  assign w_fire   = r_out_valid && out_ready;

  always_comb begin
    w_state_nx = r_state;
`ifdef EX_MULDIV_EN
    case (r_state)
      ST_IDLE:   if (w_accept && w_md_op) w_state_nx = ST_MULDIV;
      ST_MULDIV: if (w_md_done) w_state_nx = (r_out_valid && !out_ready) ? ST_HOLD : ST_IDLE;
      ST_HOLD:   if (out_ready) w_state_nx = ST_IDLE;
      default:   w_state_nx = ST_IDLE;
    endcase
    if (flush) w_state_nx = ST_IDLE;
`else
    w_state_nx = ST_IDLE;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flag      <= '0;
      r_next_pc   <= '0;
`ifdef EX_MULDIV_EN
      r_pend_pc   <= '0;
`endif
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else begin
      if (w_fire) r_out_valid <= 1'b0;
      if (w_single) begin
        r_result    <= w_alu;
        r_flag      <= w_flag;
        r_next_pc   <= w_next_pc;
        r_out_valid <= 1'b1;
      end
`ifdef EX_MULDIV_EN
      if (w_accept && w_md_op) r_pend_pc <= w_next_pc;
      if (w_md_commit) begin
        r_result    <= w_md_lo;
        r_flag      <= w_md_flag;
        r_next_pc   <= r_pend_pc;
        r_out_valid <= 1'b1;
      end
`endif
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flag      = r_flag;
  assign next_pc   = r_next_pc;

endmodule

`default_nettype wire
